// File: rtl/hazard_pkg.sv
// Shared constants and match helpers for the hazard unit and its MD busy counter.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic hit(input logic [4:0] r, input logic [4:0] w, input logic en);
    return en && (w != 5'd0) && (w == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] wm, input logic enm,
                                         input logic [4:0] ww, input logic enw);
    if (hit(r, wm, enm))      return FWD_M;
    else if (hit(r, ww, enw)) return FWD_W;
    else                      return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter; MdBusy is high while the count is nonzero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

  logic [CW-1:0] cnt_q, cnt_d;

  // A new start overrides any count in progress; a cancelled start never loads.
  always_comb begin
    cnt_d = cnt_q;
    if (start && !cancel)
      cnt_d = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding control for the five-stage MIPS pipeline.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteEnableE,
  input  logic       RegWriteEnableM,
  input  logic       RegWriteEnableW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       MdUseD,
  input  logic       MdStartE,
  input  logic       MdDivE,
  input  logic       ExcReqM,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MdBusy
);

  logic lw_stall, br_stall, md_stall, stall;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .rst_n (reset),
    .start (MdStartE),
    .is_div(MdDivE),
    .cancel(ExcReqM),
    .busy  (MdBusy)
  );

  always_comb begin
    ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteEnableM, WriteRegW, RegWriteEnableW);
    ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteEnableM, WriteRegW, RegWriteEnableW);
    ForwardAD = hit(RsD, WriteRegM, RegWriteEnableM);
    ForwardBD = hit(RtD, WriteRegM, RegWriteEnableM);

    lw_stall = MemtoRegE &&
               (hit(RsD, WriteRegE, RegWriteEnableE) || hit(RtD, WriteRegE, RegWriteEnableE));
    // D-stage compare cannot take an E result, nor an M result that is still a load.
    br_stall = BranchD &&
               (hit(RsD, WriteRegE, RegWriteEnableE) || hit(RtD, WriteRegE, RegWriteEnableE) ||
                (MemtoRegM && (hit(RsD, WriteRegM, RegWriteEnableM) ||
                               hit(RtD, WriteRegM, RegWriteEnableM))));
    md_stall = MdUseD && (MdBusy || MdStartE);

    stall  = (lw_stall || br_stall || md_stall) && !ExcReqM;
    StallF = stall;
    StallD = stall;
    FlushE = stall || ExcReqM;
    FlushD = ExcReqM;
    FlushM = ExcReqM;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench: stimulus pushes expected output bundles, a monitor pops and compares.
`timescale 1ns/1ps
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteEnableE, RegWriteEnableM, RegWriteEnableW;
  logic       MemtoRegE, MemtoRegM, BranchD, MdUseD, MdStartE, MdDivE, ExcReqM;
  logic       StallF, StallD, FlushD, FlushE, FlushM, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;

  typedef struct {
    string      name;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [11:0] act;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteEnableE(RegWriteEnableE), .RegWriteEnableM(RegWriteEnableM),
    .RegWriteEnableW(RegWriteEnableW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MdUseD(MdUseD), .MdStartE(MdStartE), .MdDivE(MdDivE), .ExcReqM(ExcReqM),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MdBusy(MdBusy)
  );

  // {StallF,StallD,FlushD,FlushE,FlushM,ForwardAD,ForwardBD,ForwardAE,ForwardBE,MdBusy}
  assign act = {StallF, StallD, FlushD, FlushE, FlushM, ForwardAD, ForwardBD,
                ForwardAE, ForwardBE, MdBusy};

  function automatic logic [11:0] ex(input logic sf, sd, fd, fe, fm, fad, fbd,
                                     input logic [1:0] fae, fbe, input logic busy);
    return {sf, sd, fd, fe, fm, fad, fbd, fae, fbe, busy};
  endfunction

  localparam logic [11:0] STALL = 12'b110100000000;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got %b want %b (SF SD FD FE FM FAD FBD FAE FBE BUSY)",
                 e.name, act, e.v);
      end
    end
  end

  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteEnableE = 0; RegWriteEnableM = 0; RegWriteEnableW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MdUseD = 0; MdStartE = 0; MdDivE = 0; ExcReqM = 0;
  endtask

  // Inputs are already applied; queue the expectation and move to the next cycle.
  task automatic chk(input string nm, input logic [11:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b0;
    #2;
    chk("reset_idle", '0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Load-use then M forward
    idle(); MemtoRegE = 1; WriteRegE = 8; RegWriteEnableE = 1; RsD = 8;
    chk("loaduse_stall", STALL);
    idle(); RsE = 8; WriteRegM = 8; RegWriteEnableM = 1; MemtoRegM = 1;
    chk("loaduse_fwdM", ex(0,0,0,0,0,0,0,2'b10,2'b00,0));

    // $0 never matches; M beats W; W alone; disabled writer
    idle(); RsE = 0; WriteRegM = 0; RegWriteEnableM = 1; WriteRegW = 0; RegWriteEnableW = 1;
    chk("zero_reg", '0);
    idle(); RsE = 5; RtE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteEnableM = 1; RegWriteEnableW = 1;
    chk("prio_M_over_W", ex(0,0,0,0,0,0,0,2'b10,2'b10,0));
    idle(); RsE = 3; RtE = 6; WriteRegM = 3; WriteRegW = 6; RegWriteEnableM = 0; RegWriteEnableW = 1;
    chk("fwd_W_only", ex(0,0,0,0,0,0,0,2'b00,2'b01,0));

    // Branch on ALU result in E, then forwarded from M, then load in M
    idle(); BranchD = 1; RtD = 9; WriteRegE = 9; RegWriteEnableE = 1;
    chk("branch_stall", STALL);
    idle(); BranchD = 1; RtD = 9; WriteRegM = 9; RegWriteEnableM = 1;
    chk("branch_fwdBD", ex(0,0,0,0,0,0,1,2'b00,2'b00,0));
    idle(); BranchD = 1; RsD = 7; WriteRegM = 7; RegWriteEnableM = 1; MemtoRegM = 1;
    chk("branch_loadM", ex(1,1,0,1,0,1,0,2'b00,2'b00,0));

    // Div occupancy with an MD user held in D
    idle(); MdStartE = 1; MdDivE = 1; MdUseD = 1;
    chk("div_c0", STALL);
    for (int c = 1; c <= 10; c++) begin
      idle(); MdUseD = 1;
      chk($sformatf("div_c%0d", c), STALL | 12'd1);
    end
    idle(); MdUseD = 1;
    chk("div_c11", '0);

    // Exception cancels start and overrides load-use stall
    idle(); ExcReqM = 1; MdStartE = 1; MemtoRegE = 1; WriteRegE = 8; RegWriteEnableE = 1; RsD = 8;
    chk("exc_flush", ex(0,0,1,1,1,0,0,2'b00,2'b00,0));
    idle();
    chk("exc_no_busy", '0);

    // Exception during a running mult count: counter keeps going
    idle(); MdStartE = 1;
    chk("mult_c0", '0);
    idle(); ExcReqM = 1; MdUseD = 1;
    chk("exc_during_count", ex(0,0,1,1,1,0,0,2'b00,2'b00,1));
    for (int c = 2; c <= 5; c++) begin
      idle();
      chk($sformatf("mult_c%0d", c), 12'd1);
    end
    idle();
    chk("mult_c6", '0);

    // Reset asserted mid-count, between clock edges
    idle(); MdStartE = 1;
    chk("rst_mult_c0", '0);
    idle();
    chk("rst_mult_c1", 12'd1);
    chk("rst_mult_c2", 12'd1);
    reset = 1'b0;
    chk("rst_async_drop", '0);
    reset = 1'b1; MdUseD = 1;
    chk("rst_released", '0);
    chk("rst_released2", '0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
